// File: rtl/pipe_hazard_ctrl_if.sv
// Handshake bundle between the fetch/decode front end and the pipeline hazard controller.
// The master side drives the fetched instruction and stage-1 source info; the slave is the controller.
interface pipe_hazard_ctrl_if #(
  parameter int INST_W = 16,
  parameter int STAGES = 4,
  parameter int RA_W   = 3
);
  localparam int SEL_W = $clog2(STAGES + 1);

  logic [INST_W-1:0]        i_inst;
  logic                     i_inst_valid;
  logic [RA_W-1:0]          i_dec_ws;
  logic                     i_dec_we;
  logic                     i_dec_late;
  logic [RA_W-1:0]          i_rs1;
  logic [RA_W-1:0]          i_rs2;
  logic                     i_rs1_use;
  logic                     i_rs2_use;
  logic                     i_flush;

  logic                     o_fetch_en;
  logic                     o_stall;
  logic [SEL_W-1:0]         o_fwd1_sel;
  logic [SEL_W-1:0]         o_fwd2_sel;
  logic [STAGES*INST_W-1:0] o_stage_inst;
  logic [STAGES-1:0]        o_stage_valid;
  logic [RA_W-1:0]          o_wb_ws;
  logic                     o_wb_we;
  logic [15:0]              o_retired;
  logic [15:0]              o_stall_cnt;

  modport master (
    output i_inst, i_inst_valid, i_dec_ws, i_dec_we, i_dec_late,
           i_rs1, i_rs2, i_rs1_use, i_rs2_use, i_flush,
    input  o_fetch_en, o_stall, o_fwd1_sel, o_fwd2_sel, o_stage_inst,
           o_stage_valid, o_wb_ws, o_wb_we, o_retired, o_stall_cnt
  );

  modport slave (
    input  i_inst, i_inst_valid, i_dec_ws, i_dec_we, i_dec_late,
           i_rs1, i_rs2, i_rs1_use, i_rs2_use, i_flush,
    output o_fetch_en, o_stall, o_fwd1_sel, o_fwd2_sel, o_stage_inst,
           o_stage_valid, o_wb_ws, o_wb_we, o_retired, o_stall_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Instruction pipe with RAW hazard detection at register read: forwards from the youngest
// matching stage when its result is ready, otherwise stalls the front; supports branch flush.
module pipe_hazard_ctrl #(
  parameter int INST_W    = 16,
  parameter int STAGES    = 4,
  parameter int RA_W      = 3,
  parameter int READY_STG = 3,
  parameter int FWD_EN    = 1,
  parameter int FLUSH_N   = 2
) (
  input logic               clk,
  input logic               reset,
  pipe_hazard_ctrl_if.slave bus
);
  localparam int SEL_W = $clog2(STAGES + 1);

  // Index k-1 holds stage k, so the packed inst array maps directly onto o_stage_inst.
  logic [STAGES-1:0][INST_W-1:0] inst_q;
  logic [STAGES-1:0][RA_W-1:0]   ws_q;
  logic [STAGES-1:0]             valid_q;
  logic [STAGES-1:0]             we_q;
  logic [STAGES-1:0]             late_q;
  logic [15:0]                   retired_q;
  logic [15:0]                   stall_cnt_q;

  logic [1:0][RA_W-1:0]  rs;
  logic [1:0]            rs_use;
  logic [1:0]            hit;
  logic [1:0]            hit_rdy;
  logic [1:0][SEL_W-1:0] hit_sel;
  logic [1:0]            src_stall;
  logic                  stall;

  assign rs     = {bus.i_rs2, bus.i_rs1};
  assign rs_use = {bus.i_rs2_use, bus.i_rs1_use};

  // Scanning oldest to youngest lets the youngest match overwrite older ones.
  always_comb begin
    hit       = '0;
    hit_rdy   = '0;
    hit_sel   = '0;
    src_stall = '0;
    for (int s = 0; s < 2; s++) begin
      for (int k = STAGES; k >= 2; k--) begin
        if (rs_use[s] && valid_q[0] && valid_q[k-1] && we_q[k-1] && (ws_q[k-1] == rs[s])) begin
          hit[s]     = 1'b1;
          hit_sel[s] = SEL_W'(k);
          hit_rdy[s] = late_q[k-1] ? (k == STAGES) : (k >= READY_STG);
        end
      end
      src_stall[s] = (FWD_EN == 0) ? hit[s] : (hit[s] && !hit_rdy[s]);
    end
  end

  assign stall = |src_stall;

  assign bus.o_stall       = stall;
  assign bus.o_fetch_en    = !stall;
  assign bus.o_fwd1_sel    = stall ? '0 : hit_sel[0];
  assign bus.o_fwd2_sel    = stall ? '0 : hit_sel[1];
  assign bus.o_stage_inst  = inst_q;
  assign bus.o_stage_valid = valid_q;
  assign bus.o_wb_ws       = ws_q[STAGES-1];
  assign bus.o_wb_we       = we_q[STAGES-1] & valid_q[STAGES-1];
  assign bus.o_retired     = retired_q;
  assign bus.o_stall_cnt   = stall_cnt_q;

  // Later assignments override the default shift: flush beats stall, stall beats input.
  always_ff @(posedge clk) begin
    if (reset) begin
      inst_q      <= '0;
      ws_q        <= '0;
      valid_q     <= '0;
      we_q        <= '0;
      late_q      <= '0;
      retired_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      for (int k = STAGES - 1; k >= 1; k--) begin
        inst_q[k]  <= inst_q[k-1];
        ws_q[k]    <= ws_q[k-1];
        valid_q[k] <= valid_q[k-1];
        we_q[k]    <= we_q[k-1];
        late_q[k]  <= late_q[k-1];
      end
      if (bus.i_flush) begin
        for (int k = 0; k < FLUSH_N; k++) begin
          inst_q[k]  <= '0;
          ws_q[k]    <= '0;
          valid_q[k] <= 1'b0;
          we_q[k]    <= 1'b0;
          late_q[k]  <= 1'b0;
        end
      end else if (stall) begin
        inst_q[1]  <= '0;
        ws_q[1]    <= '0;
        valid_q[1] <= 1'b0;
        we_q[1]    <= 1'b0;
        late_q[1]  <= 1'b0;
      end else begin
        inst_q[0]  <= bus.i_inst;
        ws_q[0]    <= bus.i_dec_ws;
        valid_q[0] <= bus.i_inst_valid;
        we_q[0]    <= bus.i_dec_we;
        late_q[0]  <= bus.i_dec_late;
      end
      if (valid_q[STAGES-1])
        retired_q <= retired_q + 16'd1;
      if (stall && (stall_cnt_q != 16'hFFFF))
        stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench: a forwarding controller (scoreboarded on retirement) and a
// stall-only controller share the same stimulus.
module tb_pipe_hazard_ctrl;
  localparam int INST_W = 16;
  localparam int STAGES = 4;
  localparam int RA_W   = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.INST_W(INST_W), .STAGES(STAGES), .RA_W(RA_W)) bus_a ();
  pipe_hazard_ctrl_if #(.INST_W(INST_W), .STAGES(STAGES), .RA_W(RA_W)) bus_b ();

  pipe_hazard_ctrl #(.INST_W(INST_W), .STAGES(STAGES), .RA_W(RA_W), .READY_STG(3),
                     .FWD_EN(1), .FLUSH_N(2))
    dut_a (.clk(clk), .reset(reset), .bus(bus_a));

  pipe_hazard_ctrl #(.INST_W(INST_W), .STAGES(STAGES), .RA_W(RA_W), .READY_STG(3),
                     .FWD_EN(0), .FLUSH_N(2))
    dut_b (.clk(clk), .reset(reset), .bus(bus_b));

  typedef struct {
    logic [INST_W-1:0] inst;
    logic [RA_W-1:0]   ws;
  } exp_t;

  exp_t sb_q[$];
  bit   sb_en = 1'b0;
  int   tests_run = 0;
  int   tests_failed = 0;

  task automatic check_output(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Drives one cycle of inputs to both controllers and records accepted instructions.
  task automatic apply_stimulus(input logic [INST_W-1:0] inst, input logic valid,
                                input logic [RA_W-1:0] ws, input logic we, input logic late,
                                input logic [RA_W-1:0] rs1, input logic use1,
                                input logic [RA_W-1:0] rs2, input logic use2,
                                input logic flush);
    @(negedge clk);
    bus_a.i_inst = inst;  bus_a.i_inst_valid = valid; bus_a.i_dec_ws = ws;
    bus_a.i_dec_we = we;  bus_a.i_dec_late = late;   bus_a.i_rs1 = rs1;
    bus_a.i_rs1_use = use1; bus_a.i_rs2 = rs2; bus_a.i_rs2_use = use2; bus_a.i_flush = flush;
    bus_b.i_inst = inst;  bus_b.i_inst_valid = valid; bus_b.i_dec_ws = ws;
    bus_b.i_dec_we = we;  bus_b.i_dec_late = late;   bus_b.i_rs1 = rs1;
    bus_b.i_rs1_use = use1; bus_b.i_rs2 = rs2; bus_b.i_rs2_use = use2; bus_b.i_flush = flush;
    #1;
    if (sb_en && valid && bus_a.o_fetch_en && !flush)
      sb_q.push_back('{inst: inst, ws: ws});
  endtask

  task automatic idle();
    apply_stimulus('0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    idle();
    reset = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb_en && !reset && bus_a.o_stage_valid[STAGES-1]) begin
      if (sb_q.size() == 0) begin
        check_output("sb_underflow", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check_output("retire_inst", 32'(bus_a.o_stage_inst[STAGES*INST_W-1 -: INST_W]), 32'(e.inst));
        check_output("retire_ws", 32'(bus_a.o_wb_ws), 32'(e.ws));
        check_output("retire_we_gate", 32'(bus_a.o_wb_we), 32'(dut_a.we_q[STAGES-1]));
      end
    end
  end

  initial begin
    do_reset();
    repeat (3) idle();
    check_output("rst_valid", 32'(bus_a.o_stage_valid), 32'd0);
    check_output("rst_fetch_en", 32'(bus_a.o_fetch_en), 32'd1);
    check_output("rst_retired", 32'(bus_a.o_retired), 32'd0);
    check_output("rst_stall_cnt", 32'(bus_a.o_stall_cnt), 32'd0);
    check_output("rst_wb_we", 32'(bus_a.o_wb_we), 32'd0);
    check_output("rst_fwd1", 32'(bus_a.o_fwd1_sel), 32'd0);

    // Stall-only controller: writer of R3 followed by a reader.
    apply_stimulus(16'h0303, 1'b1, 3'd3, 1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
    apply_stimulus(16'h1003, 1'b1, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(16'h2000, 1'b1, 3'd0, 1'b0, 1'b0, 3'd3, 1'b1, 3'd0, 1'b0, 1'b0);
      check_output("nf_stall", 32'(bus_b.o_stall), 32'd1);
      check_output("nf_fetch_en", 32'(bus_b.o_fetch_en), 32'd0);
    end
    apply_stimulus(16'h2000, 1'b1, 3'd0, 1'b0, 1'b0, 3'd3, 1'b1, 3'd0, 1'b0, 1'b0);
    check_output("nf_release", 32'(bus_b.o_stall), 32'd0);
    check_output("nf_fwd1", 32'(bus_b.o_fwd1_sel), 32'd0);
    check_output("nf_stall_cnt", 32'(bus_b.o_stall_cnt), 32'd3);

    do_reset();
    sb_en = 1'b1;

    // ALU writer of R2 then a reader: one stall, then forward from stage 3.
    apply_stimulus(16'h0042, 1'b1, 3'd2, 1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
    apply_stimulus(16'h1120, 1'b1, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
    apply_stimulus(16'h2001, 1'b1, 3'd0, 1'b0, 1'b0, 3'd2, 1'b1, 3'd0, 1'b0, 1'b0);
    check_output("alu_stall", 32'(bus_a.o_stall), 32'd1);
    check_output("alu_fetch_en", 32'(bus_a.o_fetch_en), 32'd0);
    check_output("alu_fwd1_forced", 32'(bus_a.o_fwd1_sel), 32'd0);
    apply_stimulus(16'h2001, 1'b1, 3'd0, 1'b0, 1'b0, 3'd2, 1'b1, 3'd0, 1'b0, 1'b0);
    check_output("alu_fwd1", 32'(bus_a.o_fwd1_sel), 32'd3);
    check_output("alu_no_stall", 32'(bus_a.o_stall), 32'd0);
    check_output("alu_stall_cnt", 32'(bus_a.o_stall_cnt), 32'd1);

    // Load of R5 then a reader: two stalls, then forward from stage 4.
    apply_stimulus(16'h3005, 1'b1, 3'd5, 1'b1, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
    check_output("b_in_stage2", 32'(bus_a.o_stage_inst[2*INST_W-1 -: INST_W]), 32'h1120);
    check_output("b_valid2", 32'(bus_a.o_stage_valid[1]), 32'd1);
    apply_stimulus(16'h1150, 1'b1, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      apply_stimulus(16'h2002, 1'b1, 3'd0, 1'b0, 1'b0, 3'd5, 1'b1, 3'd0, 1'b0, 1'b0);
      check_output("load_stall", 32'(bus_a.o_stall), 32'd1);
    end
    apply_stimulus(16'h2002, 1'b1, 3'd0, 1'b0, 1'b0, 3'd5, 1'b1, 3'd0, 1'b0, 1'b0);
    check_output("load_fwd1", 32'(bus_a.o_fwd1_sel), 32'd4);
    check_output("load_stall_cnt", 32'(bus_a.o_stall_cnt), 32'd3);

    // Stages 3 and 4 both write R6: the younger one (stage 3) wins.
    apply_stimulus(16'h0606, 1'b1, 3'd6, 1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
    apply_stimulus(16'h0616, 1'b1, 3'd6, 1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
    apply_stimulus(16'h2003, 1'b1, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
    apply_stimulus(16'h1260, 1'b1, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
    apply_stimulus(16'h2004, 1'b1, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd6, 1'b1, 1'b0);
    check_output("youngest_fwd2", 32'(bus_a.o_fwd2_sel), 32'd3);
    check_output("youngest_no_stall", 32'(bus_a.o_stall), 32'd0);
    check_output("youngest_fwd1", 32'(bus_a.o_fwd1_sel), 32'd0);
    bus_a.i_rs2_use = 1'b0;
    bus_b.i_rs2_use = 1'b0;
    #1;
    check_output("unused_fwd2", 32'(bus_a.o_fwd2_sel), 32'd0);
    check_output("unused_no_stall", 32'(bus_a.o_stall), 32'd0);

    // Flush during a stall: the stage-1 reader is squashed, the stage-2 writer moves on.
    apply_stimulus(16'h0707, 1'b1, 3'd7, 1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
    apply_stimulus(16'h1370, 1'b1, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
    apply_stimulus(16'h2005, 1'b1, 3'd0, 1'b0, 1'b0, 3'd7, 1'b1, 3'd0, 1'b0, 1'b1);
    check_output("flush_stall_seen", 32'(bus_a.o_stall), 32'd1);
    void'(sb_q.pop_back());
    idle();
    check_output("flush_valid1", 32'(bus_a.o_stage_valid[0]), 32'd0);
    check_output("flush_valid2", 32'(bus_a.o_stage_valid[1]), 32'd0);
    check_output("flush_inst1", 32'(bus_a.o_stage_inst[INST_W-1:0]), 32'd0);
    check_output("flush_stage3", 32'(bus_a.o_stage_inst[3*INST_W-1 -: INST_W]), 32'h0707);
    check_output("flush_stall_drop", 32'(bus_a.o_stall), 32'd0);
    check_output("flush_stall_cnt", 32'(bus_a.o_stall_cnt), 32'd4);
    repeat (4) idle();
    check_output("sb_drained", 32'(sb_q.size()), 32'd0);
    check_output("retired_count", 32'(bus_a.o_retired), 32'd12);

    // Retired counter wraps after 65536 retirements.
    sb_en = 1'b0;
    do_reset();
    check_output("rst2_retired", 32'(bus_a.o_retired), 32'd0);
    check_output("rst2_stall_cnt", 32'(bus_a.o_stall_cnt), 32'd0);
    repeat (65535) apply_stimulus(16'h2000, 1'b1, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
    repeat (6) idle();
    check_output("retired_max", 32'(bus_a.o_retired), 32'h0000FFFF);
    sb_en = 1'b1;
    apply_stimulus(16'h2BAD, 1'b1, 3'd1, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
    repeat (6) idle();
    check_output("retired_wrap", 32'(bus_a.o_retired), 32'd0);
    check_output("sb_final", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Parametrised instruction-pipeline controller for the pipelined CPU. It carries instruction words, valid bits and writeback metadata through `STAGES` pipeline stages, and detects read-after-write hazards at the register-read stage. For each hazard it either selects a forwarding source or stalls the front of the pipe. It also squashes younger stages on a taken branch and keeps retire/stall performance counters. It replaces the free-running, stall-less instruction pipe registers of the current core.

## Interface
- `INST_W`, 16, instruction word width
- `STAGES`, 4, pipeline depth; stage 1 = register read, stage `STAGES` = writeback; legal range 3..8
- `RA_W`, 3, register address width
- `READY_STG`, 3, first stage at which a non-late result can be forwarded
- `FWD_EN`, 1, 1 = forward when ready; 0 = stall on any match
- `FLUSH_N`, 2, number of youngest stages squashed by flush; 1..`STAGES`-1
- SEL_W = $clog2(`STAGES`+1) (derived)

- `clk` in 1 — single clock, rising edge
- `reset` in 1 — synchronous, active-high
- `i_inst` in `INST_W` — fetched instruction
- `i_inst_valid` in 1 — `i_inst` is valid this cycle
- `i_dec_ws` in `RA_W` — destination register of `i_inst`
- `i_dec_we` in 1 — `i_inst` writes a register
- `i_dec_late` in 1 — result is available only at stage `STAGES` (load)
- `i_rs1`, `i_rs2` in `RA_W` — source registers of the stage-1 instruction
- `i_rs1_use`, `i_rs2_use` in 1 — the corresponding source is read
- `i_flush` in 1 — taken branch resolved; squash the younger stages
- `o_fetch_en` out 1 — equals !`o_stall`; PC advances and the input is accepted
- `o_stall` out 1 — hazard stall this cycle
- `o_fwd1_sel`, `o_fwd2_sel` out SEL_W — 0 = regfile, k = forward from stage k
- `o_stage_inst` out `STAGES`*`INST_W` — stage k occupies bits [k*`INST_W`-1 : (k-1)*`INST_W`]
- `o_stage_valid` out `STAGES` — bit k-1 = stage k valid
- `o_wb_ws` out `RA_W`, `o_wb_we` out 1 — stage-`STAGES` writeback; `o_wb_we` is gated by valid
- `o_retired` out 16 — count of retired instructions
- `o_stall_cnt` out 16 — count of stall cycles

## Operation
- Each stage k holds {inst, valid, ws, we, late}.
- match_k(rs) = rs_use & valid_1 & valid_k & we_k & (ws_k == rs), for k = 2..`STAGES`.
- The youngest match (smallest k) wins.
- ready_k = late_k ? (k == `STAGES`) : (k >= `READY_STG`).
- The source stalls if `FWD_EN`=0 and any match exists, or if `FWD_EN`=1 and the youngest match is not ready.
- Otherwise fwd_sel = the youngest matching k (0 if there is no match).
- `o_stall` = stall(rs1) | stall(rs2). While `o_stall`=1, both fwd_sel outputs are forced to 0.
- Normal advance (no stall, no flush): stage 1 <= input fields, with valid = `i_inst_valid`; stage k <= stage k-1.
- Stall: stage 1 holds. Stage 2 receives a bubble (valid=0, inst=0). Stages 3..`STAGES` shift. `i_inst` is not accepted, and fetch must hold it.
- Flush: has priority over stall and over input. After the edge, stages 1..`FLUSH_N` are invalid with inst=0. Stages `FLUSH_N`+1..`STAGES` take the normal shift of their predecessors.
- Counters:
  - `o_retired` increments by 1 each cycle in which stage-`STAGES` valid=1; wraps 0xFFFF -> 0x0000.
  - `o_stall_cnt` increments each cycle `o_stall`=1; saturates at 0xFFFF.
- Register 0 gets no special treatment; every address participates in matching.

## Timing
- Reset (synchronous): all inst/valid/ws/we/late fields are 0 and both counters are 0. Consequently `o_stall`=0, `o_fetch_en`=1, fwd_sel=0 and `o_wb_we`=0 on the first cycle after reset.
- Reset mid-stall or mid-flush discards all pipeline state on that edge.
- `o_stall`, `o_fwd*_sel`, `o_fetch_en` and `o_wb_*` are combinational from stage registers and the current `i_rs*`. No registered latency is added.
- An accepted instruction appears in stage 1 one cycle after acceptance and retires at stage `STAGES` `STAGES`-1 cycles later when not stalled.
- Simultaneous `i_flush` and hazard: the flush is applied and the stage-1 instruction is squashed. `o_stall` still reflects the current comparison for that cycle, but the stall counter counts the cycle only if `o_stall`=1.
- A counter increment and reset in the same cycle: reset wins.

## Test plan
- Reset, then 3 idle cycles -> `o_stage_valid`=0, `o_fetch_en`=1, `o_retired`=0, `o_stall_cnt`=0.
- ALU A writes R2 (0x0042 format), and next instruction B reads rs1=R2 -> 1 stall cycle (A in stage 2). Then `o_fwd1_sel`=3, B enters stage 2 the following cycle, and `o_stall_cnt`=1.
- Load (late=1) writes R5, followed by a consumer of R5 -> 2 stall cycles. Then `o_fwd1_sel`=4 (`STAGES`=4) and `o_stall_cnt`=2.
- `FWD_EN`=0, with a dependent pair on R3 -> 3 stall cycles until the writer leaves stage 4. Then fwd_sel=0.
- Stages 3 and 4 both write R6, and stage 1 reads rs2=R6 -> `o_fwd2_sel`=3 (youngest match). With `i_rs2_use`=0 -> `o_fwd2_sel`=0 and no stall.
- Assert `i_flush` during a stall with `FLUSH_N`=2 -> stages 1 and 2 are invalid next cycle and `o_stall` drops.
- Preload `o_retired` to 0xFFFF via 65535 retirements, then retire 1 more -> `o_retired`=0x0000.
